// File: rtl/chacha_pkg.sv
// chacha_pkg: shared ChaCha20 word/matrix types, sigma constants and sequencer states.
package chacha_pkg;
    typedef logic [31:0] word_t;
    typedef word_t [3:0][3:0] matrix_t;
    localparam word_t SIGMA0 = 32'h6170_7865;
    localparam word_t SIGMA1 = 32'h3320_646e;
    localparam word_t SIGMA2 = 32'h7962_2d32;
    localparam word_t SIGMA3 = 32'h6b20_6574;
    typedef enum logic [1:0] {IDLE, START, WAIT, OUT} state_t;
endpackage

// File: rtl/chacha_state_builder.sv
// chacha_state_builder: combinational key/nonce/counter to ChaCha20 initial matrix (word [r][c] at bits 32*(4r+c)).
module chacha_state_builder
    import chacha_pkg::*;
(
    input  logic [255:0] key,
    input  logic [95:0]  nonce,
    input  logic [31:0]  ctr,
    output logic [511:0] state
);
    matrix_t m;
    assign m[0] = {SIGMA3, SIGMA2, SIGMA1, SIGMA0};
    assign m[1] = key[127:0];
    assign m[2] = key[255:128];
    assign m[3] = {nonce, ctr};
    assign state = m;
endmodule

// File: rtl/chacha_block_sequencer.sv
// chacha_block_sequencer: runs the ChaCha20 core once per block and buffers keystream downstream.
// CHACHA_POLY_KEYGEN_EN adds a leading counter-0 block whose rows 0-1 appear on otk.
module chacha_block_sequencer
    import chacha_pkg::*;
#(
    parameter int NBLK_W       = 16,
    parameter int CORE_TIMEOUT = 1023
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [255:0]      req_key,
    input  logic [95:0]       req_nonce,
    input  logic [31:0]       req_ctr,
    input  logic [NBLK_W-1:0] req_nblk,
    output logic              core_set,
    output logic [511:0]      core_state,
    input  logic              core_ready,
    input  logic [511:0]      core_block,
    output logic              ks_valid,
    input  logic              ks_ready,
    output logic [511:0]      ks_block,
    output logic [31:0]       ks_ctr,
    output logic              ks_last,
`ifdef CHACHA_POLY_KEYGEN_EN
    output logic [255:0]      otk,
    output logic              otk_valid,
`endif
    output logic              done,
    output logic [1:0]        err
);
    localparam int TW = $clog2(CORE_TIMEOUT + 1);

    state_t st, nx;
    logic [255:0] key_r;
    logic [95:0] nonce_r;
    word_t ctr_r, b_ctr;
    logic [NBLK_W-1:0] rem;
    logic [TW-1:0] tcnt;
    logic [511:0] mat;
    logic accept, hs, timeout, fin, wrap, kg_hit;

    assign accept    = st == IDLE && req_valid;
    assign hs        = st == OUT && ks_ready;
    assign timeout   = st == WAIT && !core_ready && tcnt == TW'(CORE_TIMEOUT - 1);
    assign fin       = hs && rem == NBLK_W'(1);
    assign wrap      = hs && !fin && ctr_r == 32'hFFFF_FFFF;
    assign req_ready = st == IDLE;
    assign core_set  = st == START;
    assign ks_valid  = st == OUT;
    assign ks_last   = ks_valid && rem == NBLK_W'(1);

`ifdef CHACHA_POLY_KEYGEN_EN
    logic otk_pend;
    assign kg_hit = st == WAIT && core_ready && otk_pend;
    assign b_ctr  = st == IDLE ? 32'd0 : (st == OUT ? ctr_r + 32'd1 : ctr_r);
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            otk       <= '0;
            otk_valid <= 1'b0;
            otk_pend  <= 1'b0;
        end else begin
            otk_valid <= kg_hit;
            if (accept) otk_pend <= 1'b1;
            if (kg_hit) begin
                otk_pend <= 1'b0;
                otk      <= core_block[255:0];
            end
        end
    end
`else
    assign kg_hit = 1'b0;
    assign b_ctr  = st == IDLE ? req_ctr : ctr_r + 32'd1;
`endif

    chacha_state_builder u_build (
        .key   (st == IDLE ? req_key : key_r),
        .nonce (st == IDLE ? req_nonce : nonce_r),
        .ctr   (b_ctr),
        .state (mat)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) st <= IDLE;
        else st <= nx;
    end

    always_comb begin
        nx = st;
        unique case (st)
            IDLE:    nx = accept && req_nblk != '0 ? START : IDLE;
            START:   nx = WAIT;
            WAIT:    nx = core_ready ? (kg_hit ? START : OUT) : (timeout ? IDLE : WAIT);
            OUT:     nx = hs ? (fin || wrap ? IDLE : START) : OUT;
            default: nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            key_r      <= '0;
            nonce_r    <= '0;
            ctr_r      <= '0;
            rem        <= '0;
            tcnt       <= '0;
            core_state <= '0;
            ks_block   <= '0;
            ks_ctr     <= '0;
            done       <= 1'b0;
            err        <= '0;
        end else begin
            done <= (accept && req_nblk == '0) || timeout || fin || wrap;
            if (accept) begin
                key_r   <= req_key;
                nonce_r <= req_nonce;
                ctr_r   <= req_ctr;
                rem     <= req_nblk;
                err     <= '0;
            end
            // core_state only moves on entry to START, so it is steady while the core runs
            if (nx == START && st != START) core_state <= mat;
            tcnt <= st == WAIT ? tcnt + 1'b1 : '0;
            if (st == WAIT && core_ready && !kg_hit) begin
                ks_block <= core_block;
                ks_ctr   <= ctr_r;
            end
            if (timeout) err[1] <= 1'b1;
            if (wrap) err[0] <= 1'b1;
            if (hs) begin
                rem   <= rem - 1'b1;
                ctr_r <= ctr_r + 32'd1;
            end
        end
    end
endmodule

// File: tb/tb_chacha_block_sequencer.sv
// tb_chacha_block_sequencer: randomized bench with a ChaCha20 core model and message-level reference.
module tb_chacha_block_sequencer;
    localparam int CT = 1023;

    logic clk, rst_n, req_valid, req_ready, core_set, core_ready, ks_valid, ks_ready, ks_last, done;
    logic [255:0] req_key;
    logic [95:0] req_nonce;
    logic [31:0] req_ctr, ks_ctr;
    logic [15:0] req_nblk;
    logic [511:0] core_state, core_block, ks_block;
    logic [1:0] err;
    logic core_hang;
    int checks, errors, nsets;

    chacha_block_sequencer #(.NBLK_W(16), .CORE_TIMEOUT(CT)) dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
        .req_key(req_key), .req_nonce(req_nonce), .req_ctr(req_ctr), .req_nblk(req_nblk),
        .core_set(core_set), .core_state(core_state), .core_ready(core_ready), .core_block(core_block),
        .ks_valid(ks_valid), .ks_ready(ks_ready), .ks_block(ks_block), .ks_ctr(ks_ctr),
        .ks_last(ks_last), .done(done), .err(err)
    );

    initial clk = 0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [511:0] got, input logic [511:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    function automatic logic [127:0] qr(input logic [31:0] a, b, c, d);
        a += b; d ^= a; d = {d[15:0], d[31:16]};
        c += d; b ^= c; b = {b[19:0], b[31:20]};
        a += b; d ^= a; d = {d[23:0], d[31:24]};
        c += d; b ^= c; b = {b[24:0], b[31:25]};
        return {a, b, c, d};
    endfunction

    function automatic logic [511:0] qrv(input logic [511:0] v, input int a, b, c, d);
        {v[32*a+:32], v[32*b+:32], v[32*c+:32], v[32*d+:32]} =
            qr(v[32*a+:32], v[32*b+:32], v[32*c+:32], v[32*d+:32]);
        return v;
    endfunction

    function automatic logic [511:0] chacha(input logic [511:0] s);
        logic [511:0] v = s;
        for (int r = 0; r < 10; r++) begin
            v = qrv(v, 0, 4, 8, 12); v = qrv(v, 1, 5, 9, 13);
            v = qrv(v, 2, 6, 10, 14); v = qrv(v, 3, 7, 11, 15);
            v = qrv(v, 0, 5, 10, 15); v = qrv(v, 1, 6, 11, 12);
            v = qrv(v, 2, 7, 8, 13); v = qrv(v, 3, 4, 9, 14);
        end
        for (int i = 0; i < 16; i++) v[32*i+:32] = v[32*i+:32] + s[32*i+:32];
        return v;
    endfunction

    function automatic logic [511:0] build(input logic [255:0] k, input logic [95:0] n, input logic [31:0] c);
        logic [31:0] w[16];
        w[0] = 32'h61707865; w[1] = 32'h3320646e; w[2] = 32'h79622d32; w[3] = 32'h6b206574;
        for (int i = 0; i < 8; i++) w[4+i] = k[32*i+:32];
        w[12] = c;
        for (int i = 0; i < 3; i++) w[13+i] = n[32*i+:32];
        for (int i = 0; i < 16; i++) build[32*i+:32] = w[i];
    endfunction

    // core model: drops ready on each core_set, answers after a random latency unless hung
    initial begin
        logic [511:0] snap;
        core_ready = 0;
        core_block = '0;
        forever begin
            @(negedge clk);
            if (core_set) begin
                nsets++;
                snap = core_state;
                core_ready = 0;
                if (!core_hang) begin
                    repeat ($urandom_range(1, 12)) @(negedge clk);
                    chk("core_state_stable", core_state, snap);
                    core_block = chacha(snap);
                    core_ready = 1;
                end
            end
        end
    end

    task automatic run_msg(input logic [255:0] k, input logic [95:0] n, input logic [31:0] c,
                           input logic [15:0] nb, input int stall_idx, input logic hang);
        longint room;
        int exp_n, exp_sets, got_n, dones, sets0, k_set, k_done, stalled, cyc, d;
        logic [1:0] exp_err;
        logic [511:0] hb;
        logic [31:0] hc, ec;
        logic hl, holding, seen_valid;
        room = 64'h1_0000_0000 - c;
        exp_n = hang ? 0 : (nb > room ? int'(room) : int'(nb));
        exp_sets = hang ? 1 : exp_n;
        exp_err = hang ? 2'b10 : (nb > room ? 2'b01 : 2'b00);
        got_n = 0; dones = 0; k_set = -1; k_done = -1; stalled = 0; cyc = 0;
        holding = 0; seen_valid = 0;
        core_hang = hang;
        @(negedge clk);
        chk("req_ready", req_ready, 1);
        req_key = k; req_nonce = n; req_ctr = c; req_nblk = nb; req_valid = 1;
        sets0 = nsets;
        @(negedge clk);
        req_valid = 0;
        req_key = {8{$urandom}};
        req_ctr = $urandom;
        while (dones == 0 && cyc < 3000) begin
            if (core_set && k_set < 0) k_set = cyc;
            if (done) begin dones++; k_done = cyc; end
            if (ks_valid) begin
                seen_valid = 1;
                if (!holding) begin
                    hb = ks_block; hc = ks_ctr; hl = ks_last; holding = 1; stalled = 0;
                end
                ks_ready = (got_n == stall_idx && stalled < 10) ? 1'b0 : ($urandom_range(0, 3) != 0);
                if (ks_ready) begin
                    if (stalled > 0) begin
                        chk("ks_stable", ks_block, hb);
                        chk("ks_stable_ctr", {ks_ctr, ks_last}, {hc, hl});
                    end
                    ec = c + got_n;
                    chk("ks_ctr", ks_ctr, ec);
                    chk("ks_block", ks_block, chacha(build(k, n, ec)));
                    chk("ks_last", ks_last, got_n == int'(nb) - 1);
                    got_n++;
                    holding = 0;
                end else stalled++;
            end else ks_ready = $urandom_range(0, 1);
            cyc++;
            if (dones == 0) @(negedge clk);
        end
        repeat (3) begin
            @(negedge clk);
            if (done) dones++;
            if (ks_valid) seen_valid = 1;
        end
        chk("nblocks", got_n, exp_n);
        chk("done_cnt", dones, 1);
        chk("err", err, exp_err);
        chk("core_sets", nsets - sets0, exp_sets);
        chk("idle", req_ready, 1);
        if (nb == 0) chk("done_lat", k_done, 0);
        if (hang) begin
            d = k_done - k_set;
            chk("timeout_lat", d >= CT && d <= CT + 1, 1);
            chk("ks_valid_hang", seen_valid, 0);
        end
    endtask

    initial begin
        logic [255:0] k;
        logic [95:0] n;
        checks = 0; errors = 0; nsets = 0; core_hang = 0;
        rst_n = 0; req_valid = 0; req_key = '0; req_nonce = '0; req_ctr = '0; req_nblk = '0; ks_ready = 0;
        repeat (3) @(negedge clk);
        chk("rst_ctl", {req_ready, core_set, ks_valid, ks_last, done, err, ks_ctr}, {1'b1, 38'b0});
        chk("rst_core_state", core_state, '0);
        chk("rst_ks_block", ks_block, '0);
        rst_n = 1;

        for (int i = 0; i < 32; i++) k[8*i+:8] = 8'(i);
        run_msg(k, {32'h0, 32'h4a000000, 32'h09000000}, 32'd1, 16'd1, -1, 0);
        chk("rfc_word0", ks_block[31:0], 32'he4e7f110);
        chk("rfc_ctr", ks_ctr, 32'd1);

        run_msg({8{$urandom}}, {3{$urandom}}, 32'd5, 16'd3, 1, 0);
        run_msg({8{$urandom}}, {3{$urandom}}, 32'hFFFF_FFFE, 16'd4, -1, 0);
        run_msg({8{$urandom}}, {3{$urandom}}, 32'd9, 16'd1, -1, 1);
        run_msg({8{$urandom}}, {3{$urandom}}, 32'd3, 16'd0, -1, 0);
        for (int t = 0; t < 5; t++) begin
            for (int i = 0; i < 8; i++) k[32*i+:32] = $urandom;
            for (int i = 0; i < 3; i++) n[32*i+:32] = $urandom;
            run_msg(k, n, t % 2 ? $urandom : 32'hFFFF_FFFF - $urandom_range(0, 3),
                    16'($urandom_range(1, 5)), $urandom_range(0, 2), 0);
        end

        core_hang = 1;
        @(negedge clk);
        req_key = {8{$urandom}}; req_nonce = {3{$urandom}}; req_ctr = 32'd77; req_nblk = 16'd2; req_valid = 1;
        @(negedge clk);
        req_valid = 0;
        repeat (5) @(negedge clk);
        #2 rst_n = 0;
        #1;
        chk("arst_ctl", {req_ready, core_set, ks_valid, ks_last, done, err, ks_ctr}, {1'b1, 38'b0});
        chk("arst_core_state", core_state, '0);
        chk("arst_ks_block", ks_block, '0);
        repeat (2) @(negedge clk);
        rst_n = 1;
        core_hang = 0;
        repeat (15) @(negedge clk);
        run_msg({8{$urandom}}, {3{$urandom}}, 32'd100, 16'd2, -1, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
